// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage feeding a DEPTH-entry FIFO of decoded bundles.
// Define DECODE_M_EXT_EN to accept M-extension OP encodings (funct7=0000001).
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_illegal,
  output logic [6:0]          out_opcode,
  output logic [31:0]         out_imm,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_rs1_used,
  output logic                out_rs2_used,
  output logic                out_rd_we,
  output logic [3:0]          out_alu_op,
  output logic                out_negate_alu_lsb,
  output logic [1:0]          out_load_store_size,
  output logic                out_load_high,
  output logic                out_muldiv
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;

  // Register-register ALU codes are {funct7[5], funct3}; EQ sits in a free slot.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SLL = 4'd1;
  localparam logic [3:0] ALU_LT  = 4'd2;
  localparam logic [3:0] ALU_LTU = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd8;
  localparam logic [3:0] ALU_EQ  = 4'd9;
  localparam logic [3:0] ALU_SRA = 4'd13;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                illegal;
    logic [6:0]          opcode;
    logic [31:0]         imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rs1_used;
    logic                rs2_used;
    logic                rd_we;
    logic [3:0]          alu_op;
    logic                negate;
    logic [1:0]          ls_size;
    logic                load_high;
    logic                muldiv;
  } dec_t;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t        fld, dec, head;
  logic        legal;

  assign opc   = in_inst[6:0];
  assign rd    = in_inst[11:7];
  assign f3    = in_inst[14:12];
  assign rs1   = in_inst[19:15];
  assign rs2   = in_inst[24:20];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    fld   = '0;
    legal = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC: begin
        legal   = 1'b1;
        fld.imm = imm_u;
        fld.rd  = rd;
      end
      OP_JAL: begin
        legal   = 1'b1;
        fld.imm = imm_j;
        fld.rd  = rd;
      end
      OP_JALR: begin
        legal        = (f3 == 3'b000);
        fld.imm      = imm_i;
        fld.rs1      = rs1;
        fld.rs1_used = 1'b1;
        fld.rd       = rd;
      end
      OP_MISC: legal = 1'b1;
      OP_BRANCH: begin
        legal        = (f3[2:1] != 2'b01);
        fld.imm      = imm_b;
        fld.rs1      = rs1;
        fld.rs2      = rs2;
        fld.rs1_used = 1'b1;
        fld.rs2_used = 1'b1;
        fld.negate   = f3[0];
        case (f3[2:1])
          2'b00:   fld.alu_op = ALU_EQ;
          2'b10:   fld.alu_op = ALU_LT;
          default: fld.alu_op = ALU_LTU;
        endcase
      end
      OP_LOAD: begin
        legal         = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        fld.imm       = imm_i;
        fld.rs1       = rs1;
        fld.rs1_used  = 1'b1;
        fld.rd        = rd;
        fld.alu_op    = ALU_ADD;
        fld.ls_size   = f3[1:0];
        fld.load_high = f3[2];
      end
      OP_STORE: begin
        legal        = !f3[2] && (f3[1:0] != 2'b11);
        fld.imm      = imm_s;
        fld.rs1      = rs1;
        fld.rs2      = rs2;
        fld.rs1_used = 1'b1;
        fld.rs2_used = 1'b1;
        fld.alu_op   = ALU_ADD;
        fld.ls_size  = f3[1:0];
      end
      OP_IMM: begin
        fld.rs1      = rs1;
        fld.rs1_used = 1'b1;
        fld.rd       = rd;
        if (f3 == 3'b001) begin
          legal      = (f7 == 7'b0000000);
          fld.imm    = {27'b0, rs2};
          fld.alu_op = ALU_SLL;
        end else if (f3 == 3'b101) begin
          legal      = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          fld.imm    = {27'b0, rs2};
          fld.alu_op = f7[5] ? ALU_SRA : {1'b0, f3};
        end else begin
          legal      = 1'b1;
          fld.imm    = imm_i;
          fld.alu_op = {1'b0, f3};
        end
      end
      OP_OP: begin
        fld.rs1      = rs1;
        fld.rs2      = rs2;
        fld.rs1_used = 1'b1;
        fld.rs2_used = 1'b1;
        fld.rd       = rd;
        if (f7 == 7'b0000000) begin
          legal      = 1'b1;
          fld.alu_op = {1'b0, f3};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal      = 1'b1;
          fld.alu_op = f3[2] ? ALU_SRA : ALU_SUB;
        end
`ifdef DECODE_M_EXT_EN
        else if (f7 == 7'b0000001) begin
          legal      = 1'b1;
          fld.muldiv = 1'b1;
          fld.alu_op = {1'b0, f3};
        end
`endif
      end
      default: legal = 1'b0;
    endcase
    // rd is only populated by writeback formats, so a nonzero rd means a write.
    fld.rd_we   = (fld.rd != 5'd0);
    dec         = legal ? fld : '0;
    dec.pc      = in_pc;
    dec.opcode  = opc;
    dec.illegal = !legal;
  end

  dec_t          mem_q [DEPTH];
  dec_t          mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop;

  assign push = in_valid && in_ready_q && !flush;
  assign pop  = (count_q != '0) && out_ready && !flush;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = dec;
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
      end
      if (pop)
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
      if (push && !pop)
        count_d = count_q + CW'(1);
      else if (pop && !push)
        count_d = count_q - CW'(1);
    end
    // Registered so that in_ready never depends combinationally on out_ready.
    in_ready_d = (count_d < DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != '0);
  assign head      = out_valid ? mem_q[rptr_q] : '0;

  assign out_pc              = head.pc;
  assign out_illegal         = head.illegal;
  assign out_opcode          = head.opcode;
  assign out_imm             = head.imm;
  assign out_rs1             = head.rs1;
  assign out_rs2             = head.rs2;
  assign out_rd              = head.rd;
  assign out_rs1_used        = head.rs1_used;
  assign out_rs2_used        = head.rs2_used;
  assign out_rd_we           = head.rd_we;
  assign out_alu_op          = head.alu_op;
  assign out_negate_alu_lsb  = head.negate;
  assign out_load_store_size = head.ls_size;
  assign out_load_high       = head.load_high;
  assign out_muldiv          = head.muldiv;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed stimulus for decode_queue, checked every cycle against a
// queue-based reference model plus hand-computed literal expectations.
module tb_decode_queue;
  localparam int DEPTH = 2;
  localparam int PCW   = 32;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        in_ready, out_valid, out_illegal, out_rs1_used, out_rs2_used, out_rd_we;
  logic        out_negate_alu_lsb, out_load_high, out_muldiv;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_load_store_size;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_opcode(out_opcode), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used), .out_rd_we(out_rd_we),
    .out_alu_op(out_alu_op), .out_negate_alu_lsb(out_negate_alu_lsb),
    .out_load_store_size(out_load_store_size), .out_load_high(out_load_high),
    .out_muldiv(out_muldiv)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        illegal;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        r1u, r2u, we;
    logic [3:0]  alu;
    logic        neg;
    logic [1:0]  size;
    logic        lh, md;
  } exp_t;

  localparam logic [3:0] A_ADD = 4'd0, A_SLL = 4'd1, A_LT = 4'd2, A_LTU = 4'd3, A_XOR = 4'd4,
                         A_SRL = 4'd5, A_OR = 4'd6, A_AND = 4'd7, A_SUB = 4'd8, A_EQ = 4'd9,
                         A_SRA = 4'd13;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_LT;
      3'd3: return A_LTU;
      3'd4: return A_XOR;
      3'd5: return A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // Reference decode written straight from the format/legality rules.
  function automatic exp_t mdec(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic ok, r1, r2, wr;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; ok = 0; r1 = 0; r2 = 0; wr = 0;
    f3 = w[14:12]; f7 = w[31:25];
    case (w[6:0])
      7'h37, 7'h17: begin ok = 1; wr = 1; e.imm = w & 32'hFFFFF000; end
      7'h6F: begin ok = 1; wr = 1; e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      7'h67: begin ok = (f3 == 0); r1 = 1; wr = 1; e.imm = 32'($signed(w[31:20])); end
      7'h0F: ok = 1;
      7'h63: begin
        ok = !(f3 inside {3'd2, 3'd3}); r1 = 1; r2 = 1;
        e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        e.alu = (f3 < 2) ? A_EQ : ((f3 < 6) ? A_LT : A_LTU);
        e.neg = f3[0];
      end
      7'h03: begin
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; r1 = 1; wr = 1;
        e.imm = 32'($signed(w[31:20])); e.size = f3[1:0]; e.lh = f3[2];
      end
      7'h23: begin
        ok = (f3 <= 2); r1 = 1; r2 = 1;
        e.imm = 32'($signed({w[31:25], w[11:7]})); e.size = f3[1:0];
      end
      7'h13: begin
        r1 = 1; wr = 1;
        if (f3 == 1 || f3 == 5) begin
          ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
          e.imm = {27'b0, w[24:20]};
          e.alu = (f7 == 7'h20) ? A_SRA : base_alu(f3);
        end else begin
          ok = 1; e.imm = 32'($signed(w[31:20])); e.alu = base_alu(f3);
        end
      end
      7'h33: begin
        r1 = 1; r2 = 1; wr = 1;
        if (f7 == 0) begin ok = 1; e.alu = base_alu(f3); end
        else if (f7 == 7'h20 && f3 == 0) begin ok = 1; e.alu = A_SUB; end
        else if (f7 == 7'h20 && f3 == 5) begin ok = 1; e.alu = A_SRA; end
`ifdef DECODE_M_EXT_EN
        else if (f7 == 7'h01) begin ok = 1; e.md = 1; e.alu = {1'b0, f3}; end
`endif
      end
      default: ok = 0;
    endcase
    e.r1u = r1; e.r2u = r2;
    if (r1) e.rs1 = w[19:15];
    if (r2) e.rs2 = w[24:20];
    if (wr && w[11:7] != 0) begin e.rd = w[11:7]; e.we = 1; end
    if (!ok) e = '0;
    e.pc = pc; e.opcode = w[6:0]; e.illegal = !ok;
    return e;
  endfunction

  exp_t mq[$];
  bit   m_rdy = 1;
  bit   do_pop, do_push;

  // Model state update on each active edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || flush) begin
      mq.delete();
      m_rdy = 1;
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && m_rdy;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(mdec(in_inst, in_pc));
      m_rdy = (mq.size() < DEPTH);
    end
  end

  exp_t act, expv;
  initial forever begin
    @(negedge clk);
    act = {out_pc, out_illegal, out_opcode, out_imm, out_rs1, out_rs2, out_rd,
           out_rs1_used, out_rs2_used, out_rd_we, out_alu_op, out_negate_alu_lsb,
           out_load_store_size, out_load_high, out_muldiv};
    expv = (mq.size() != 0) ? mq[0] : '0;
    chk("cyc_out_valid", out_valid, mq.size() != 0);
    chk("cyc_in_ready", in_ready, m_rdy);
    chk("cyc_head", act, expv);
  end

  task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
    in_inst = w; in_pc = pc; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  logic [31:0] stream [] = '{32'h00209463, 32'h0020E463, 32'h0020A463, 32'h0040C083,
                             32'h0040B083, 32'h00112423, 32'h00113423, 32'h000080E7,
                             32'h000090E7, 32'h00000073, 32'h0000000F, 32'h00209093,
                             32'h40209093, 32'h4020D093, 32'h8020D093, 32'h002081B3,
                             32'h402081B3, 32'h0020F1B3, 32'h800000B7, 32'h00001097,
                             32'h00000033, 32'hFFFFFFFF};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    rst_n = 1; out_ready = 1;
    @(negedge clk);

    push_one(32'hFFB00093, 32'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_alu", out_alu_op, A_ADD);
    chk("addi_imm", out_imm, 32'hFFFFFFFB);
    chk("addi_rd", out_rd, 1);
    chk("addi_flags", {out_rd_we, out_rs1_used, out_rs2_used}, 3'b110);
    @(negedge clk);

    // Back-pressure: third instruction is held until a slot frees.
    out_ready = 0;
    in_inst = 32'h00100113; in_pc = 32'h200; in_valid = 1; @(negedge clk);
    in_inst = 32'h00200193; in_pc = 32'h204; @(negedge clk);
    chk("bp_full_ready", in_ready, 0);
    in_inst = 32'h00300213; in_pc = 32'h208; @(negedge clk);
    chk("bp_held_ready", in_ready, 0);
    chk("bp_head_pc", out_pc, 32'h200);
    out_ready = 1; @(negedge clk);
    out_ready = 0;
    chk("bp_ready_back", in_ready, 1);
    chk("bp_still_valid", out_valid, 1);
    chk("bp_pc2", out_pc, 32'h204);
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    chk("bp_pc2_again", out_pc, 32'h204);
    @(negedge clk);
    chk("bp_pc3", out_pc, 32'h208);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    // SRA legal, funct7=0100000 with funct3=001 illegal.
    out_ready = 0;
    in_inst = 32'h40005033; in_pc = 32'h300; in_valid = 1; @(negedge clk);
    in_inst = 32'h40001033; in_pc = 32'h304; @(negedge clk);
    in_valid = 0;
    chk("sra_alu", out_alu_op, A_SRA);
    chk("sra_illegal", out_illegal, 0);
    out_ready = 1; @(negedge clk);
    chk("ill_flag", out_illegal, 1);
    chk("ill_pc", out_pc, 32'h304);
    chk("ill_opcode", out_opcode, 7'h33);
    chk("ill_zero", {out_imm, out_alu_op, out_rs1_used, out_rs2_used, out_rd_we, out_rs2}, 0);
    @(negedge clk);

    // Flush with a full queue and a pending enqueue.
    out_ready = 0;
    in_inst = 32'h0000A103; in_pc = 32'h400; in_valid = 1; @(negedge clk);
    in_inst = 32'h00112223; in_pc = 32'h404; @(negedge clk);
    in_inst = 32'h00500293; in_pc = 32'h408; flush = 1; @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    @(negedge clk);
    chk("flush_absent", out_valid, 0);

    // Flush while in_ready is high: the same-cycle enqueue must be dropped.
    in_inst = 32'h00500293; in_pc = 32'h500; in_valid = 1; @(negedge clk);
    in_inst = 32'h00600313; in_pc = 32'h504; flush = 1; @(negedge clk);
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_enq_dropped", out_valid, 0);

    out_ready = 1;
    push_one(32'h02208033, 32'h600);
`ifdef DECODE_M_EXT_EN
    chk("mul_md", out_muldiv, 1);
    chk("mul_alu", out_alu_op, 0);
    chk("mul_illegal", out_illegal, 0);
`else
    chk("mul_illegal", out_illegal, 1);
    chk("mul_md", out_muldiv, 0);
`endif
    @(negedge clk);

    push_one(32'h12345537, 32'h610);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_rd", {out_rd, out_rd_we, out_rs1_used}, {5'd10, 2'b10});
    @(negedge clk);
    push_one(32'hFF9FF06F, 32'h614);
    chk("jal_neg_imm", out_imm, 32'hFFFFFFF8);
    chk("jal_x0_we", out_rd_we, 0);
    @(negedge clk);
    push_one(32'h00209463, 32'h618);
    chk("bne_imm", out_imm, 32'h8);
    chk("bne_alu_neg", {out_alu_op, out_negate_alu_lsb}, {A_EQ, 1'b1});
    @(negedge clk);
    push_one(32'h00112423, 32'h61C);
    chk("sw_imm", out_imm, 32'h8);
    chk("sw_size", {out_load_store_size, out_rd_we}, 3'b100);
    @(negedge clk);

    for (int i = 0; i < stream.size(); i++) begin
      in_inst = stream[i]; in_pc = 32'h700 + 32'(4 * i); in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered RV32I decode stage between fetch and execute, parametrised in buffer depth and PC width.
- Accepts fetched instructions over a valid/ready handshake, decodes them fully and stores the decoded bundles in a DEPTH-entry FIFO.
- Presents the oldest bundle downstream with its own valid/ready handshake.
- Adds a pipeline flush, explicit illegal-instruction reporting and register-usage flags.

Parameters:
- DEPTH, 2, number of decoded-entry slots; power of two, 1 to 16.
- PC_WIDTH, 32, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all buffered entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; registered.
- in_inst  in  32  instruction word.
- in_pc  in  PC_WIDTH  instruction address.
- out_valid  out  1  head entry present.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  PC_WIDTH  PC of the head entry.
- out_illegal  out  1  head entry is an illegal instruction.
- out_opcode  out  7  inst[6:0].
- out_imm  out  32  sign- or zero-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_rs1_used, out_rs2_used, out_rd_we  out  1 each  operand-use flags and writeback enable.
- out_alu_op  out  4  ALU_* code.
- out_negate_alu_lsb  out  1  branch result inversion.
- out_load_store_size  out  2  funct3[1:0].
- out_load_high  out  1  funct3[2] for loads (zero-extend).
- out_muldiv  out  1  M-extension op; 0 when the option is absent.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, read/write pointers 0, in_ready=1, out_valid=0.
  - Every out_* field reads 0.
- Decode is combinational on in_inst and is written into the slot at the write pointer when in_valid && in_ready.
- Latency: an instruction accepted at edge N gives out_valid=1 after edge N when the queue was empty. Throughput is 1 per cycle.
- in_ready is a registered flag equal to (count < DEPTH).
  - It has no combinational path from out_ready.
  - A full queue that dequeues in cycle N raises in_ready from cycle N+1.
- out_valid = (count != 0). Head fields come from the slot at the read pointer; they read 0 when the queue is empty.
- Same-cycle enqueue and dequeue leaves count unchanged and advances both pointers. Pointers wrap modulo DEPTH.
- flush=1: count, pointers and out_valid clear at the edge, and in_ready=1 afterwards. Any same-cycle enqueue or dequeue is discarded. Flush has priority over all other events.
- Decoded fields are deterministic:
  - Any field unused by the format reads 0.
  - rs*_used=0 implies rs*=0.
- out_rd_we is 1 for U/J/JALR/LOAD/OP_IMM/OP formats with rd!=0, and 0 otherwise.
- Legality (out_illegal=1 otherwise; an illegal entry is still queued with its pc and opcode, and all other fields 0):
  - LUI, AUIPC, JAL, JALR (funct3=000), MISC_MEM.
  - BRANCH funct3 not in {010, 011}. funct3[2:1] maps 00 to ALU_EQ, 10 to ALU_LT, 11 to ALU_LTU; negate_alu_lsb = funct3[0].
  - LOAD funct3 in {000, 001, 010, 100, 101}.
  - STORE funct3 in {000, 001, 010}.
  - OP_IMM: SLLI requires funct7=0000000. SRLI/SRAI require funct7 of 0000000 or 0100000; funct7[5] selects ALU_SRA. Shift imm = {27'b0, inst[24:20]}.
  - OP: funct7=0000000 for all funct3, or funct7=0100000 only for funct3 000 (ALU_SUB) and 101 (ALU_SRA).
  - Every other opcode, including SYSTEM, is illegal.
- Immediates:
  - I/S/B/J sign-extended from inst[31].
  - U = {inst[31:12], 12'b0}.

Optional Feature:
- Macro DECODE_M_EXT_EN.
- Defined: OP with funct7=0000001 is legal. It sets out_muldiv=1, out_alu_op={1'b0, funct3}, rs1_used=rs2_used=1 and rd_we when rd!=0.
- Undefined: funct7=0000001 is illegal and out_muldiv is tied 0.

Test Plan:
- Reset then push ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 → next cycle: out_valid=1, alu_op=ALU_ADD, imm=0xFFFFFFFB, rd=1, rd_we=1, rs1_used=1, rs2_used=0.
- DEPTH=2, out_ready=0, push 3 back-to-back → in_ready drops after the 2nd accept and the 3rd is held. Raise out_ready for 1 cycle → in_ready=1 the following cycle and order is preserved.
- Push 0x40005033 (SRA) and then 0x40001033 (funct7 0100000 with funct3 001) → first gives alu_op=ALU_SRA, illegal=0; second gives illegal=1, out_pc correct, other fields 0.
- Queue holding 2 entries, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction is absent.
- Full queue with in_valid=1 and out_ready=1 in the same cycle → the dequeue happens, the enqueue does not, and count goes 2→1.
- Push 0x02208033 (MUL) → with DECODE_M_EXT_EN: muldiv=1, alu_op=0, illegal=0. Without it: illegal=1.
